// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard sequencer for the IF/ID and ID/EX pipeline registers of the 5-stage CPU.
//   - Load-use hazard: holds PC and IF/ID and sends bubbles into ID/EX for LOAD_STALL cycles.
//   - Taken jump resolved in EX: flushes IF/ID and bubbles ID/EX for FLUSH_LEN cycles.
//   - mem_busy: freezes PC, IF/ID and ID/EX. State, remaining count and counters do not move.
//   - EX operand forwarding selects (00 regfile, 01 MEM, 10 WB). MEM has priority over WB.
//   - Saturating counters of inserted bubbles and flush cycles.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs1, id_rs2, id_uses_rs2     source operands of the instruction in ID
//   ex_rs1, ex_rs2                  source operands of the instruction in EX
//   ex_write_reg, ex_reg_wrenable,
//   ex_mem_to_reg, ex_is_jump       destination and type of the instruction in EX
//   mem_write_reg, mem_reg_wrenable destination of the instruction in MEM
//   wb_write_reg, wb_reg_wrenable   destination of the instruction in WB
//   mem_busy                        data memory not ready
//   pc_hold, ifid_hold, ifid_flush,
//   idex_hold, idex_bubble          pipeline register controls (combinational, same cycle)
//   fwd_a, fwd_b                    EX operand selects
//   stall_cnt, flush_cnt            saturating performance counters
//   dbg_state, dbg_rem              FSM state (0 RUN, 1 STALL, 2 FLUSH) and remaining cycles
// There is no valid/ready handshake: every input is sampled each cycle as a level, and every
// control output applies to the cycle in which it is asserted.
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int FLUSH_LEN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_wrenable,
  input  logic             ex_mem_to_reg,
  input  logic             ex_is_jump,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_reg_wrenable,
  input  logic [REG_W-1:0] wb_write_reg,
  input  logic             wb_reg_wrenable,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state,
  output logic [7:0]       dbg_rem
);

  localparam int REM_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               lu_haz;
  logic               pc_hold_c, ifid_hold_c, ifid_flush_c, idex_hold_c, idex_bubble_c;
  logic [1:0]         fwd_a_c, fwd_b_c;

  // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] mem_rd,
    input logic             mem_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (mem_we && (mem_rd == src)) begin
        sel = 2'b01;
      end else if (wb_we && (wb_rd == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    lu_haz = ex_reg_wrenable & ex_mem_to_reg & (ex_write_reg != '0) &
             ((ex_write_reg == id_rs1) | (id_uses_rs2 & (ex_write_reg == id_rs2)));

    fwd_a_c = fwd_sel(ex_rs1, mem_write_reg, mem_reg_wrenable, wb_write_reg, wb_reg_wrenable);
    fwd_b_c = fwd_sel(ex_rs2, mem_write_reg, mem_reg_wrenable, wb_write_reg, wb_reg_wrenable);

    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_hold_c   = 1'b0;
    idex_bubble_c = 1'b0;
    state_d       = state_q;
    rem_d         = rem_q;

    if (mem_busy) begin
      // Full freeze. A jump still sitting in EX is acted on once busy drops.
      pc_hold_c   = 1'b1;
      ifid_hold_c = 1'b1;
      idex_hold_c = 1'b1;
    end else if (ex_is_jump) begin
      // PC is left free so the jump target loads this cycle.
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_d = ST_FLUSH;
        rem_d   = REM_W'(FLUSH_LEN - 1);
      end else begin
        state_d = ST_RUN;
        rem_d   = '0;
      end
    end else begin
      case (state_q)
        ST_STALL: begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = ST_RUN;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
        ST_FLUSH: begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = ST_RUN;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
        default: begin
          if (lu_haz) begin
            pc_hold_c     = 1'b1;
            ifid_hold_c   = 1'b1;
            idex_bubble_c = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = ST_STALL;
              rem_d   = REM_W'(LOAD_STALL - 1);
            end
          end
        end
      endcase
    end

    // Bubbles that coincide with a flush are charged to the flush counter only.
    stall_cnt_d = stall_cnt_q;
    if (idex_bubble_c && !ifid_flush_c && !mem_busy && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (ifid_flush_c && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The combinational controls are masked while reset is asserted so that nothing downstream
  // sees a hold, flush or forward select before the pipeline is released.
  assign pc_hold     = rst_n & pc_hold_c;
  assign ifid_hold   = rst_n & ifid_hold_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_hold   = rst_n & idex_hold_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign fwd_a       = rst_n ? fwd_a_c : 2'b00;
  assign fwd_b       = rst_n ? fwd_b_c : 2'b00;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_rem     = rem_q;

endmodule
